// File: rtl/disp_fifo_unpack.sv
// R-channel capture FIFO with burst back-pressure and 32->16 bit pixel unpacker.
// Single ACLK domain; block RAM storage with a prefetched head word.
module disp_fifo_unpack #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned AW          = 9,
  parameter int unsigned BURST_WORDS = 16,
  parameter int unsigned MARGIN      = 4
) (
  input  logic          ACLK,
  input  logic          ARST,
  input  logic [31:0]   RDATA,
  input  logic          RVALID,
  input  logic          RREADY,
  input  logic          RLAST,
  output logic          FIFOREADY,
  input  logic          FLUSH,
  input  logic          PIXEN,
  output logic [15:0]   PIXDATA,
  output logic          PIXVALID,
  output logic [AW:0]   LEVEL,
  input  logic          FLAGCLR,
  output logic          UNDERRUN,
  output logic          OVERFLOW,
  output logic          BURSTERR
);

  localparam int unsigned CW         = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam logic [AW:0] DEPTH_W    = (AW+1)'(DEPTH);
  localparam logic [AW:0] READY_FREE = (AW+1)'(BURST_WORDS + MARGIN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_WORDS - 1);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ram_q;

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          ram_vld_q, ram_vld_d;
  logic [31:0]   head_q, head_d;
  logic          head_vld_q, head_vld_d;
  logic          half_q, half_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          fifo_ready_q, fifo_ready_d;
  logic [15:0]   pixdata_q, pixdata_d;
  logic          pixvalid_q, pixvalid_d;
  logic          underrun_q, underrun_d;
  logic          overflow_q, overflow_d;
  logic          bursterr_q, bursterr_d;

  logic          beat, push, pop, full;
  logic          und_set, ovf_set, berr_set;
  logic [AW:0]   level, level_nxt;

  // Read address follows the next-cycle read pointer so a popped word's
  // successor is already on the RAM output one cycle after the pop.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= RDATA;
    ram_q <= mem[rd_ptr_d[AW-1:0]];
  end

  always_comb begin
    level     = wr_ptr_q - rd_ptr_q;
    full      = (level == DEPTH_W);
    beat      = RVALID & RREADY;
    pop       = PIXEN & head_vld_q & half_q & ~FLUSH;
    push      = beat & ~FLUSH & (~full | pop);
    ovf_set   = beat & ~FLUSH & full & ~pop;

    wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d  = FLUSH ? wr_ptr_q : rd_ptr_q + (AW+1)'(pop);
    level_nxt = wr_ptr_d - rd_ptr_d;
    fifo_ready_d = (DEPTH_W - level_nxt) >= READY_FREE;

    // RAM output is trusted only if the addressed word was written before this edge.
    ram_vld_d = (rd_ptr_d != wr_ptr_q);

    head_d     = head_q;
    head_vld_d = head_vld_q;
    if (FLUSH || pop) begin
      head_vld_d = 1'b0;
    end else if (!head_vld_q && ram_vld_q) begin
      head_d     = ram_q;
      head_vld_d = 1'b1;
    end

    pixvalid_d = PIXEN;
    pixdata_d  = pixdata_q;
    half_d     = half_q;
    und_set    = 1'b0;
    if (PIXEN) begin
      if (FLUSH) begin
        pixdata_d = '0;
      end else if (!head_vld_q) begin
        pixdata_d = '0;
        und_set   = 1'b1;
      end else begin
        pixdata_d = half_q ? head_q[31:16] : head_q[15:0];
        half_d    = ~half_q;
      end
    end
    if (FLUSH) half_d = 1'b0;

    beat_cnt_d = beat_cnt_q;
    berr_set   = 1'b0;
    if (FLUSH) begin
      beat_cnt_d = '0;
    end else if (beat) begin
      if (RLAST) begin
        beat_cnt_d = '0;
        berr_set   = (beat_cnt_q != LAST_BEAT);
      end else if (beat_cnt_q == LAST_BEAT) begin
        beat_cnt_d = '0;
        berr_set   = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    underrun_d = und_set  | (underrun_q & ~FLAGCLR);
    overflow_d = ovf_set  | (overflow_q & ~FLAGCLR);
    bursterr_d = berr_set | (bursterr_q & ~FLAGCLR);
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_vld_q    <= 1'b0;
      head_q       <= '0;
      head_vld_q   <= 1'b0;
      half_q       <= 1'b0;
      beat_cnt_q   <= '0;
      fifo_ready_q <= 1'b0;
      pixdata_q    <= '0;
      pixvalid_q   <= 1'b0;
      underrun_q   <= 1'b0;
      overflow_q   <= 1'b0;
      bursterr_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_vld_q    <= ram_vld_d;
      head_q       <= head_d;
      head_vld_q   <= head_vld_d;
      half_q       <= half_d;
      beat_cnt_q   <= beat_cnt_d;
      fifo_ready_q <= fifo_ready_d;
      pixdata_q    <= pixdata_d;
      pixvalid_q   <= pixvalid_d;
      underrun_q   <= underrun_d;
      overflow_q   <= overflow_d;
      bursterr_q   <= bursterr_d;
    end
  end

  assign FIFOREADY = fifo_ready_q;
  assign PIXDATA   = pixdata_q;
  assign PIXVALID  = pixvalid_q;
  assign LEVEL     = level;
  assign UNDERRUN  = underrun_q;
  assign OVERFLOW  = overflow_q;
  assign BURSTERR  = bursterr_q;

endmodule
